// File: rtl/ysyx_22040750_pc_fetch.sv
// ysyx_22040750_pc_fetch
//   PC register and instruction-fetch sequencer.
//   It holds the architectural fetch PC and issues one instruction-memory
//   request per PC. The fetched word is then delivered, together with pc and
//   snpc, to IF/ID under a valid/ready handshake. After delivery the block
//   waits for the next dnpc before it fetches again.
//
// Ports
//   I_clk, I_rst                 clock, async active-high reset
//   I_dnpc/I_dnpc_valid          next PC from next-PC generator
//   O_dnpc_ready                 high only while waiting for a dnpc
//   O_imem_req_valid/O_imem_addr fetch request (address = current pc)
//   I_imem_req_ready             memory accepts request
//   I_imem_rsp_valid/_data       one-cycle response pulse with instruction
//   O_inst_valid/I_inst_ready    delivery handshake to IF/ID
//   O_inst, O_pc, O_snpc         delivered instruction, its pc, pc+SNPC_INC
//   I_flush                      kill current fetch, wait for redirect dnpc
//   O_misalign                   sticky: a dnpc with [1:0]!=0 was accepted
module ysyx_22040750_pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] SNPC_INC = 32'd4
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic [31:0] I_dnpc,
  input  logic        I_dnpc_valid,
  output logic        O_dnpc_ready,
  output logic        O_imem_req_valid,
  output logic [31:0] O_imem_addr,
  input  logic        I_imem_req_ready,
  input  logic        I_imem_rsp_valid,
  input  logic [31:0] I_imem_rsp_data,
  output logic        O_inst_valid,
  input  logic        I_inst_ready,
  output logic [31:0] O_inst,
  output logic [31:0] O_pc,
  output logic [31:0] O_snpc,
  input  logic        I_flush,
  output logic        O_misalign
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2,
    S_NPC  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        drop;
  logic        misalign;

  // State register
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) state <= S_REQ;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ: begin
        if (I_flush)               state_nxt = S_NPC;
        else if (I_imem_req_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // A response that arrives with a pending or simultaneous flush is dropped.
        if (I_imem_rsp_valid) state_nxt = (drop || I_flush) ? S_NPC : S_OUT;
      end
      S_OUT: begin
        if (I_flush || I_inst_ready) state_nxt = S_NPC;
      end
      S_NPC: begin
        if (I_dnpc_valid) state_nxt = S_REQ;
      end
      default: state_nxt = S_REQ;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    O_imem_req_valid = 1'b0;
    O_inst_valid     = 1'b0;
    O_dnpc_ready     = 1'b0;
    case (state)
      // Flush in REQ suppresses the request in the same cycle.
      S_REQ:   O_imem_req_valid = ~I_flush;
      S_OUT:   O_inst_valid     = 1'b1;
      S_NPC:   O_dnpc_ready     = 1'b1;
      default: ;
    endcase
  end

  // Datapath: pc, latched instruction, drop flag, sticky misalign
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      pc       <= RESET_PC;
      inst     <= '0;
      drop     <= 1'b0;
      misalign <= 1'b0;
    end else begin
      case (state)
        S_WAIT: begin
          if (I_imem_rsp_valid) begin
            if (!drop && !I_flush) inst <= I_imem_rsp_data;
            drop <= 1'b0;
          end else if (I_flush) begin
            drop <= 1'b1;
          end
        end
        S_NPC: begin
          if (I_dnpc_valid) begin
            pc <= I_dnpc;
            if (I_dnpc[1:0] != 2'b00) misalign <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign O_imem_addr = pc;
  assign O_inst      = inst;
  assign O_pc        = pc;
  assign O_snpc      = pc + SNPC_INC;
  assign O_misalign  = misalign;

endmodule

// File: tb/tb_ysyx_22040750_pc_fetch.sv
// Directed bench for ysyx_22040750_pc_fetch. Inputs are driven 1 time unit
// after the rising edge and outputs are checked shortly after that.
module tb_ysyx_22040750_pc_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dnpc;
  logic        dnpc_valid;
  logic        dnpc_ready;
  logic        req_valid;
  logic [31:0] addr;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] snpc;
  logic        flush;
  logic        misalign;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned req_cnt = 0;

  always #5 clk = ~clk;

  ysyx_22040750_pc_fetch #(
    .RESET_PC(32'h8000_0000),
    .SNPC_INC(32'd4)
  ) dut (
    .I_clk           (clk),
    .I_rst           (rst),
    .I_dnpc          (dnpc),
    .I_dnpc_valid    (dnpc_valid),
    .O_dnpc_ready    (dnpc_ready),
    .O_imem_req_valid(req_valid),
    .O_imem_addr     (addr),
    .I_imem_req_ready(req_ready),
    .I_imem_rsp_valid(rsp_valid),
    .I_imem_rsp_data (rsp_data),
    .O_inst_valid    (inst_valid),
    .I_inst_ready    (inst_ready),
    .O_inst          (inst),
    .O_pc            (pc),
    .O_snpc          (snpc),
    .I_flush         (flush),
    .O_misalign      (misalign)
  );

  // Count accepted fetch requests
  always @(posedge clk) begin
    if (!rst && req_valid && req_ready) req_cnt <= req_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; dnpc = '0; dnpc_valid = 1'b0; req_ready = 1'b0;
    rsp_valid = 1'b0; rsp_data = '0; inst_ready = 1'b0; flush = 1'b0;
    #1;
    // Reset values
    chk("rst_req_valid", {31'd0, req_valid}, 32'd1);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_dnpc_ready", {31'd0, dnpc_ready}, 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
    chk("rst_pc", pc, 32'h8000_0000);
    chk("rst_snpc", snpc, 32'h8000_0004);
    step();
    #2 rst = 1'b0;
    step();

    // 1: first fetch
    req_ready = 1'b1;
    #1 chk("t1_addr", addr, 32'h8000_0000);
    step();                                    // -> WAIT
    chk("t1_wait_req_valid", {31'd0, req_valid}, 32'd0);
    rsp_valid = 1'b1; rsp_data = 32'h0000_0013;
    #1 chk("t1_wait_inst_valid", {31'd0, inst_valid}, 32'd0);
    step();                                    // -> OUT
    rsp_valid = 1'b0;
    chk("t1_inst_valid", {31'd0, inst_valid}, 32'd1);
    chk("t1_inst", inst, 32'h0000_0013);
    chk("t1_pc", pc, 32'h8000_0000);
    chk("t1_snpc", snpc, 32'h8000_0004);

    // 3 + 2: hold in OUT for 5 cycles with dnpc already valid
    dnpc = 32'h8000_0100; dnpc_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_hold_valid", {31'd0, inst_valid}, 32'd1);
      chk("t3_hold_inst", inst, 32'h0000_0013);
      chk("t3_hold_pc", pc, 32'h8000_0000);
      chk("t2_dnpc_ready_out", {31'd0, dnpc_ready}, 32'd0);
    end
    inst_ready = 1'b1;
    step();                                    // -> NPC
    inst_ready = 1'b0;
    chk("t2_npc_dnpc_ready", {31'd0, dnpc_ready}, 32'd1);
    chk("t2_npc_inst_valid", {31'd0, inst_valid}, 32'd0);
    step();                                    // dnpc accepted -> REQ
    dnpc_valid = 1'b0;
    #1;
    chk("t2_addr", addr, 32'h8000_0100);
    chk("t2_req_valid", {31'd0, req_valid}, 32'd1);
    chk("t2_dnpc_ready_req", {31'd0, dnpc_ready}, 32'd0);
    step();                                    // -> WAIT
    chk("t2_req_cnt", req_cnt, 32'd2);
    chk("t2_wait_req_valid", {31'd0, req_valid}, 32'd0);

    // 4: flush in WAIT, late response dropped
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    chk("t4_inst_valid_a", {31'd0, inst_valid}, 32'd0);
    chk("t4_dnpc_ready_a", {31'd0, dnpc_ready}, 32'd0);
    step();
    rsp_valid = 1'b1; rsp_data = 32'hDEAD_BEEF;
    step();                                    // dropped -> NPC
    rsp_valid = 1'b0;
    chk("t4_inst_valid_b", {31'd0, inst_valid}, 32'd0);
    chk("t4_dnpc_ready_b", {31'd0, dnpc_ready}, 32'd1);
    chk("t4_inst_kept", inst, 32'h0000_0013);
    dnpc = 32'h8000_0200; dnpc_valid = 1'b1;
    step();                                    // -> REQ
    dnpc_valid = 1'b0;
    chk("t4_addr", addr, 32'h8000_0200);
    step();                                    // -> WAIT
    rsp_valid = 1'b1; rsp_data = 32'h0010_0093;
    step();                                    // -> OUT
    rsp_valid = 1'b0;
    chk("t4_inst", inst, 32'h0010_0093);
    chk("t4_pc", pc, 32'h8000_0200);
    chk("t4_snpc", snpc, 32'h8000_0204);
    inst_ready = 1'b1;
    step();                                    // -> NPC
    inst_ready = 1'b0;

    // 5: misaligned dnpc, then wrap of snpc
    chk("t5_misalign_pre", {31'd0, misalign}, 32'd0);
    dnpc = 32'h8000_0102; dnpc_valid = 1'b1;
    step();                                    // -> REQ
    dnpc_valid = 1'b0;
    chk("t5_misalign", {31'd0, misalign}, 32'd1);
    chk("t5_addr", addr, 32'h8000_0102);
    step();                                    // -> WAIT
    rsp_valid = 1'b1; rsp_data = 32'h0000_0073;
    step();                                    // -> OUT
    rsp_valid = 1'b0;
    inst_ready = 1'b1;
    step();                                    // -> NPC
    inst_ready = 1'b0;
    dnpc = 32'hFFFF_FFFC; dnpc_valid = 1'b1;
    step();                                    // -> REQ
    dnpc_valid = 1'b0;
    chk("t5_wrap_addr", addr, 32'hFFFF_FFFC);
    chk("t5_wrap_snpc", snpc, 32'h0000_0000);
    chk("t5_misalign_sticky", {31'd0, misalign}, 32'd1);

    // Flush in REQ suppresses the request; flush in NPC is ignored
    flush = 1'b1;
    #1 chk("fr_req_valid", {31'd0, req_valid}, 32'd0);
    step();                                    // -> NPC
    chk("fr_dnpc_ready", {31'd0, dnpc_ready}, 32'd1);
    dnpc = 32'h8000_0300; dnpc_valid = 1'b1;   // flush still high
    step();                                    // -> REQ
    flush = 1'b0; dnpc_valid = 1'b0;
    #1;
    chk("fn_addr", addr, 32'h8000_0300);
    chk("fn_req_valid", {31'd0, req_valid}, 32'd1);

    // Flush in OUT: not delivered
    step();                                    // -> WAIT
    rsp_valid = 1'b1; rsp_data = 32'h1234_5678;
    step();                                    // -> OUT
    rsp_valid = 1'b0;
    chk("fo_inst_valid", {31'd0, inst_valid}, 32'd1);
    flush = 1'b1;
    step();                                    // -> NPC
    flush = 1'b0;
    chk("fo_inst_valid_after", {31'd0, inst_valid}, 32'd0);
    chk("fo_dnpc_ready", {31'd0, dnpc_ready}, 32'd1);

    // 6: async reset mid-WAIT
    dnpc = 32'h8000_0400; dnpc_valid = 1'b1;
    step();                                    // -> REQ
    dnpc_valid = 1'b0;
    step();                                    // -> WAIT
    chk("t6_pre_req_valid", {31'd0, req_valid}, 32'd0);
    #3 rst = 1'b1;
    #1;
    chk("t6_req_valid", {31'd0, req_valid}, 32'd1);
    chk("t6_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("t6_dnpc_ready", {31'd0, dnpc_ready}, 32'd0);
    chk("t6_inst", inst, 32'h0);
    chk("t6_misalign", {31'd0, misalign}, 32'd0);
    chk("t6_pc", pc, 32'h8000_0000);
    chk("t6_snpc", snpc, 32'h8000_0004);
    #1 rst = 1'b0;
    #1 chk("t6_addr", addr, 32'h8000_0000);
    step();                                    // -> WAIT
    chk("t6_wait", {31'd0, req_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
